// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: packs 4 bytes little-endian per word and
// writes them from address 0 up, holding the core in reset. Optional macro: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned PC_SIZE  = 32,
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_SIZE-1:0] word_count,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [PC_SIZE-1:0] wr_address,
    output logic [31:0]        wr_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [PC_SIZE-1:0] LastAddr = PC_SIZE'(MEM_SIZE - 1);

    logic [1:0]         state_q, state_d;
    logic [PC_SIZE-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [PC_SIZE-1:0] words_q, words_d;
    logic [PC_SIZE-1:0] count_q, count_d;
    logic               error_q, error_d;
    // Blocks a start pulse landing on the first edge after reset release.
    logic               arm_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
    logic               chk_q, chk_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        count_d    = count_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        chk_d      = chk_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start && arm_q) begin
                    count_d    = word_count;
                    addr_d     = '0;
                    words_d    = '0;
                    byte_cnt_d = '0;
                    error_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = '0;
                    chk_d      = (word_count == '0);
                    state_d    = StLoad;
`else
                    state_d    = (word_count == '0) ? StDone : StLoad;
`endif
                end
            end
            StLoad: begin
                if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    if (chk_q) begin
                        error_d = (in_data != xor_q);
                        chk_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        xor_d = xor_q ^ in_data;
`endif
                        data_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = StWrite;
                        end
`ifdef LOADER_CHECKSUM_EN
                    end
`endif
                end
            end
            StWrite: begin
                addr_d  = addr_q + PC_SIZE'(1);
                words_d = words_q + PC_SIZE'(1);
                if (words_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = 1'b1;
                    state_d = StLoad;
`else
                    state_d = StDone;
`endif
                end else if (addr_q == LastAddr) begin
                    // Memory full before the requested count: stop and flag overflow.
                    error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            words_q    <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            arm_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            count_q    <= count_d;
            error_q    <= error_d;
            arm_q      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            chk_q      <= chk_d;
`endif
        end
    end

    assign in_ready   = (state_q == StLoad);
    assign wr_en      = (state_q == StWrite);
    assign busy       = (state_q == StLoad) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign cpu_hold   = (state_q != StDone);
    assign error      = error_q;
    assign wr_address = addr_q;
    assign wr_data    = data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (MEM_SIZE=4 so overflow is reachable quickly).
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, wr_en, cpu_hold, busy, done, error;
    logic [31:0] wr_address, wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wcy[$];

    instr_mem_loader #(.PC_SIZE(32), .MEM_SIZE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_count(word_count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_address);
            wd.push_back(wr_data);
            wcy.push_back(cyc);
            checks++;
            if (wr_address > 32'd3) begin
                errors++;
                $display("FAIL wr_addr_range got %0d want <= 3", wr_address);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wcy.delete();
    endtask

    task automatic do_start(input logic [31:0] wc);
        start = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte until accepted; acc is the cycle in which the handshake happened.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_timeout got in_ready=%b want 1", in_ready);
        end
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, output int acc4);
        int a;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap, a);
        end
        acc4 = a;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        word_count = '0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_address !== 32'd0 || wr_data !== 32'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got addr=%h data=%h err=%b want 0/0/0",
                     wr_address, wr_data, error);
        end
        // Release reset with start already high: must be ignored.
        reset = 1'b1;
        start = 1'b1;
        word_count = 32'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, cpu_hold, done, wr_en} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_idle got rdy/busy/hold/done/wr=%b%b%b%b%b want 00100",
                     in_ready, busy, cpu_hold, done, wr_en);
        end
    endtask

    task automatic test_basic();
        int a0, a1, t;
        clear_log();
        do_start(32'd2);
        send_word(32'h0000_0013, 0, a0);
        send_word(32'h0010_0093, 0, a1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h90, 0, t);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL basic_count got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'd0 || wd[0] !== 32'h0000_0013) begin
                errors++;
                $display("FAIL basic_w0 got %h@%0d want 00000013@0", wd[0], wa[0]);
            end
            checks++;
            if (wa[1] !== 32'd1 || wd[1] !== 32'h0010_0093) begin
                errors++;
                $display("FAIL basic_w1 got %h@%0d want 00100093@1", wd[1], wa[1]);
            end
        end
        checks++;
        if ({done, cpu_hold, error, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done got done/hold/err/busy=%b%b%b%b want 1000",
                     done, cpu_hold, error, busy);
        end
    endtask

    task automatic test_toggle();
        int a0, a1, t;
        clear_log();
        do_start(32'd2);
        checks++;
        if ({done, cpu_hold, busy} !== 3'b011) begin
            errors++;
            $display("FAIL restart got done/hold/busy=%b%b%b want 011", done, cpu_hold, busy);
        end
        send_word(32'h0000_0013, 1, a0);
        send_word(32'h0010_0093, 1, a1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h90, 1, t);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL toggle_count got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wd[0] !== 32'h0000_0013 || wd[1] !== 32'h0010_0093 || wa[1] !== 32'd1) begin
                errors++;
                $display("FAIL toggle_data got %h %h@%0d want 00000013 00100093@1",
                         wd[0], wd[1], wa[1]);
            end
            checks++;
            if (wcy[0] != a0 + 1 || wcy[1] != a1 + 1) begin
                errors++;
                $display("FAIL toggle_latency got %0d,%0d want %0d,%0d",
                         wcy[0], wcy[1], a0 + 1, a1 + 1);
            end
        end
    endtask

    task automatic test_zero();
        int t;
        clear_log();
        do_start(32'd0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0, t);
`endif
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b err=%b want 1 0", done, error);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL zero_writes got %0d want 0", wa.size());
        end
    endtask

    task automatic test_start_ignored();
        int t;
        clear_log();
        do_start(32'd1);
        send_byte(8'h11, 0, t);
        send_byte(8'h22, 0, t);
        do_start(32'd5);
        send_byte(8'h33, 0, t);
        send_byte(8'h44, 0, t);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h44, 0, t);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 1) begin
            errors++;
            $display("FAIL ignore_count got %0d want 1", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'd0 || wd[0] !== 32'h4433_2211) begin
                errors++;
                $display("FAIL ignore_word got %h@%0d want 44332211@0", wd[0], wa[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done got done=%b err=%b want 1 0", done, error);
        end
    endtask

    task automatic test_overflow();
        int t, hs;
        logic [31:0] exp_w[4];
        exp_w[0] = 32'h0302_0100;
        exp_w[1] = 32'h0706_0504;
        exp_w[2] = 32'h0b0a_0908;
        exp_w[3] = 32'h0f0e_0d0c;
        clear_log();
        do_start(32'd6);
        for (int i = 0; i < 4; i++) send_word(exp_w[i], 0, t);
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL ovf_count got %0d want 4", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[i] !== 32'(i) || wd[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL ovf_word%0d got %h@%0d want %h@%0d",
                             i, wd[i], wa[i], exp_w[i], i);
                end
            end
        end
        checks++;
        if ({done, error, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_done got done/err/rdy=%b%b%b want 110", done, error, in_ready);
        end
        hs = 0;
        in_valid = 1'b1;
        in_data = 8'h10;
        repeat (8) begin
            if (in_ready === 1'b1) hs++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (hs != 0) begin
            errors++;
            $display("FAIL ovf_unconsumed got %0d handshakes want 0", hs);
        end
    endtask

    task automatic test_reset_midload();
        int t;
        clear_log();
        do_start(32'd2);
        send_byte(8'hAA, 0, t);
        send_byte(8'hBB, 0, t);
        in_valid = 1'b1;
        in_data = 8'hCC;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, cpu_hold, done, wr_en, error} !== 6'b001000 ||
            wr_address !== 32'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL midload_reset got flags=%b%b%b%b%b%b addr=%h data=%h want 001000/0/0",
                     in_ready, busy, cpu_hold, done, wr_en, error, wr_address, wr_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midload_after got writes=%0d rdy=%b done=%b want 0 0 0",
                     wa.size(), in_ready, done);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int t;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            do_start(32'd1);
            send_word(32'h0804_0201, 0, t);
            send_byte((k == 0) ? 8'h0F : 8'h0E, 0, t);
            repeat (2) @(negedge clk);
            checks++;
            if (done !== 1'b1 || error !== (k == 1)) begin
                errors++;
                $display("FAIL chk%0d_err got done=%b err=%b want 1 %0d", k, done, error, k);
            end
            checks++;
            if (wa.size() != 1 || wd[0] !== 32'h0804_0201) begin
                errors++;
                $display("FAIL chk%0d_word got n=%0d data=%h want 1 08040201",
                         k, wa.size(), wd[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_zero();
        test_start_ignored();
        test_overflow();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
